// File: rtl/mem_stream_loader_if.sv
// Bundle of the loader's handshake and bus signals.
//   start/base/len      : load command (base/len sampled with start)
//   s_data/s_valid/s_ready : byte stream, valid/ready handshake
//   busy/done           : load status
//   cpu_we/cpu_a/cpu_wd/cpu_rd : CPU-side memory port
//   mem_we/mem_a/mem_wd/mem_rd : memory-side port (mem_rd is async read data)
// slave  : the loader's view.
// master : the environment's view (command source, stream source, CPU and memory).
interface mem_stream_loader_if #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] len;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              busy;
  logic              done;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_a;
  logic [WORD_W-1:0] cpu_wd;
  logic [WORD_W-1:0] cpu_rd;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [WORD_W-1:0] mem_wd;
  logic [WORD_W-1:0] mem_rd;

  modport slave (
    input  start, base, len, s_data, s_valid, cpu_we, cpu_a, cpu_wd, mem_rd,
    output s_ready, busy, done, cpu_rd, mem_we, mem_a, mem_wd
  );

  modport master (
    output start, base, len, s_data, s_valid, cpu_we, cpu_a, cpu_wd, mem_rd,
    input  s_ready, busy, done, cpu_rd, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/mem_stream_loader.sv
// Upstream write port of the unified memory. Packs a byte stream into
// little-endian words and writes them to consecutive addresses starting at a
// programmed base (wrapping modulo DEPTH). Used for boot loading of program
// and data. While no load runs, the CPU port passes straight through to memory.
// Ports:
//   clk   : system clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : mem_stream_loader_if.slave -- command, byte stream, status,
//           CPU port and memory port
module mem_stream_loader #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_stream_loader_if.slave    bus
);
  localparam int BYTES = WORD_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] cnt;
  logic [IDX_W-1:0]  byte_idx;
  logic [WORD_W-1:0] word;
  logic              last_byte;

  assign last_byte = (byte_idx == IDX_W'(BYTES - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start) state_nxt = (bus.len != '0) ? FILL : DONE;
      FILL:  if (bus.s_valid && last_byte) state_nxt = WRITE;
      WRITE: state_nxt = (cnt == ADDR_W'(1)) ? DONE : FILL;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: passthrough by default, CPU blocked while a load owns the memory
  always_comb begin
    bus.s_ready = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.mem_we  = bus.cpu_we;
    bus.mem_a   = bus.cpu_a;
    bus.mem_wd  = bus.cpu_wd;
    bus.cpu_rd  = bus.mem_rd;
    case (state)
      FILL: begin
        bus.s_ready = 1'b1;
        bus.busy    = 1'b1;
        bus.mem_we  = 1'b0;
        bus.cpu_rd  = '0;
      end
      WRITE: begin
        bus.busy    = 1'b1;
        bus.mem_we  = 1'b1;
        bus.mem_a   = addr;
        bus.mem_wd  = word;
        bus.cpu_rd  = '0;
      end
      DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: address/count tracking and little-endian word assembly.
  // In FILL s_ready is high, so s_valid alone marks a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      cnt      <= '0;
      byte_idx <= '0;
      word     <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start && bus.len != '0) begin
          addr     <= bus.base;
          cnt      <= bus.len;
          byte_idx <= '0;
        end
        FILL: if (bus.s_valid) begin
          for (int b = 0; b < BYTES; b++)
            if (byte_idx == IDX_W'(b)) word[8*b +: 8] <= bus.s_data;
          byte_idx <= last_byte ? '0 : byte_idx + IDX_W'(1);
        end
        WRITE: begin
          addr <= (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + ADDR_W'(1);
          cnt  <= cnt - ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stream_loader.sv
module tb_mem_stream_loader;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_stream_loader_if #(.WORD_W(16), .ADDR_W(8)) bus ();

  mem_stream_loader #(.WORD_W(16), .ADDR_W(8), .DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory model: async read, sync write
  logic [15:0] mem [256];
  assign bus.mem_rd = mem[bus.mem_a];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_a] <= bus.mem_wd;

  // Event monitor
  int          cyc = 0, done_cnt = 0, last_we_cyc = -10, done_cyc = -20, rdy_viol = 0;
  logic [7:0]  wa_q [$];
  logic [15:0] wd_q [$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_we) begin
      wa_q.push_back(bus.mem_a);
      wd_q.push_back(bus.mem_wd);
      last_we_cyc <= cyc;
      if (bus.s_ready) rdy_viol <= rdy_viol + 1;
    end
    if (bus.done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  int total = 0, passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input logic [7:0] b[$], input bit gapped);
    int i = 0;
    int guard = 0;
    while (i < b.size() && guard < 400) begin
      bus.s_data  = b[i];
      bus.s_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bus.s_valid && bus.s_ready) i++;
      tick();
      guard++;
    end
    bus.s_valid = 1'b0;
    if (guard >= 400) chk("stream_timeout", 32'(i), 32'(b.size()));
  endtask

  task automatic wait_done();
    int k = 0;
    while (!bus.done && k < 10) begin tick(); k++; end
    if (k >= 10) chk("done_timeout", 0, 1);
  endtask

  task automatic run_load(input logic [7:0] base, input logic [7:0] len,
                          input logic [7:0] b[$], input bit gapped);
    bus.start = 1'b1; bus.base = base; bus.len = len;
    tick();
    bus.start = 1'b0;
    send_bytes(b, gapped);
    wait_done();
    tick();
  endtask

  task automatic check_load(input string tag, input int n0, input int d0,
                            input logic [7:0] base, input logic [15:0] w[$]);
    chk({tag, "_nwrites"}, 32'(wa_q.size() - n0), 32'(w.size()));
    for (int k = 0; k < w.size() && n0 + k < wa_q.size(); k++) begin
      chk({tag, "_addr"}, 32'(wa_q[n0+k]), 32'((base + k) % 16));
      chk({tag, "_data"}, 32'(wd_q[n0+k]), 32'(w[k]));
    end
    chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 1);
    chk({tag, "_done_lat"}, 32'(done_cyc - last_we_cyc), 1);
    chk({tag, "_rdy_in_write"}, 32'(rdy_viol), 0);
  endtask

  task automatic cpu_read(input string name, input logic [7:0] a, input logic [15:0] exp);
    bus.cpu_we = 1'b0; bus.cpu_a = a;
    #1;
    chk(name, 32'(bus.cpu_rd), 32'(exp));
    tick();
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  a;
    logic [15:0] wd;
    logic        chk_rd;
    logic [15:0] rd;
  } pt_vec_t;

  initial begin
    pt_vec_t     pt [4];
    logic [7:0]  bq [$];
    logic [15:0] wq [$];
    int n0, d0;

    pt[0] = '{1'b1, 8'd3, 16'h1234, 1'b0, 16'h0000};
    pt[1] = '{1'b1, 8'd7, 16'hABCD, 1'b0, 16'h0000};
    pt[2] = '{1'b0, 8'd3, 16'h0000, 1'b1, 16'h1234};
    pt[3] = '{1'b0, 8'd7, 16'h0000, 1'b1, 16'hABCD};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.base = '0; bus.len = '0;
    bus.s_data = '0; bus.s_valid = 1'b0;
    bus.cpu_we = 1'b0; bus.cpu_a = '0; bus.cpu_wd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_status", {29'b0, bus.busy, bus.done, bus.s_ready}, 0);
    #4 rst_n = 1'b1;
    tick();

    // 1. passthrough
    foreach (pt[i]) begin
      bus.cpu_we = pt[i].we; bus.cpu_a = pt[i].a; bus.cpu_wd = pt[i].wd;
      #1;
      chk("pt_mem_we", 32'(bus.mem_we), 32'(pt[i].we));
      chk("pt_mem_a", 32'(bus.mem_a), 32'(pt[i].a));
      if (pt[i].we) chk("pt_mem_wd", 32'(bus.mem_wd), 32'(pt[i].wd));
      if (pt[i].chk_rd) chk("pt_cpu_rd", 32'(bus.cpu_rd), 32'(pt[i].rd));
      chk("pt_status", {29'b0, bus.busy, bus.done, bus.s_ready}, 0);
      tick();
    end
    bus.cpu_we = 1'b0;

    // 2. basic load
    n0 = wa_q.size(); d0 = done_cnt;
    bq = {8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
    wq = {16'h1234, 16'h5678, 16'h9ABC};
    run_load(8'd2, 8'd3, bq, 1'b0);
    check_load("load", n0, d0, 8'd2, wq);
    cpu_read("rd_mem2", 8'd2, 16'h1234);
    cpu_read("rd_mem4", 8'd4, 16'h9ABC);

    // 3. same load, gapped valid
    n0 = wa_q.size(); d0 = done_cnt;
    run_load(8'd2, 8'd3, bq, 1'b1);
    check_load("gapped", n0, d0, 8'd2, wq);
    cpu_read("rd_mem3", 8'd3, 16'h5678);

    // 4. address wrap
    n0 = wa_q.size(); d0 = done_cnt;
    bq = {8'h11, 8'h22, 8'h33, 8'h44};
    wq = {16'h2211, 16'h4433};
    run_load(8'd15, 8'd2, bq, 1'b0);
    check_load("wrap", n0, d0, 8'd15, wq);
    cpu_read("rd_mem0", 8'd0, 16'h4433);

    // 5. zero-length load
    n0 = wa_q.size(); d0 = done_cnt;
    bus.start = 1'b1; bus.base = 8'd5; bus.len = 8'd0;
    #1;
    chk("len0_busy_idle", 32'(bus.busy), 0);
    tick();
    bus.start = 1'b0;
    chk("len0_done", 32'(bus.done), 1);
    chk("len0_busy", 32'(bus.busy), 0);
    tick();
    chk("len0_done_clear", 32'(bus.done), 0);
    chk("len0_busy_after", 32'(bus.busy), 0);
    chk("len0_nwrites", 32'(wa_q.size() - n0), 0);
    chk("len0_done_cnt", 32'(done_cnt - d0), 1);

    // 6. start/cpu_we while busy, then reset mid-load
    n0 = wa_q.size();
    bus.start = 1'b1; bus.base = 8'd5; bus.len = 8'd3;
    tick();
    bus.start = 1'b0;
    bq = {8'hAA, 8'hBB, 8'hCC};
    send_bytes(bq, 1'b0);
    bus.start = 1'b1; bus.base = 8'd0; bus.len = 8'd1;
    bus.cpu_we = 1'b1; bus.cpu_a = 8'd9; bus.cpu_wd = 16'hDEAD;
    #1;
    chk("busy_mem_we", 32'(bus.mem_we), 0);
    chk("busy_cpu_rd", 32'(bus.cpu_rd), 0);
    chk("busy_flag", 32'(bus.busy), 1);
    tick();
    bus.start = 1'b0; bus.cpu_we = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 1);
    chk("busy_no_done", 32'(bus.done), 0);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_s_ready", 32'(bus.s_ready), 0);
    tick();
    #3 rst_n = 1'b1;
    repeat (3) tick();
    chk("rst_nwrites", 32'(wa_q.size() - n0), 1);
    chk("rst_status", {29'b0, bus.busy, bus.done, bus.s_ready}, 0);
    cpu_read("rd_mem5", 8'd5, 16'hBBAA);
    cpu_read("rd_mem6_untouched", 8'd6, 16'h0000 | mem[6]);

    // fresh load after reset
    n0 = wa_q.size(); d0 = done_cnt;
    bq = {8'hEF, 8'hBE};
    wq = {16'hBEEF};
    run_load(8'd8, 8'd1, bq, 1'b0);
    check_load("fresh", n0, d0, 8'd8, wq);
    cpu_read("rd_mem8", 8'd8, 16'hBEEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
